commit_trace_buffer: RTL and testbench

Synthesizable capture stage that sits directly downstream of the CPU writeback/commit signals (GPR write, HI/LO write, CP0 write). Each cycle while capture is enabled, it classifies the commit event, tags it with a running cycle index, and stores it in a FIFO. A debug consumer (UART dumper, on-chip checker) drains the FIFO through a valid/ready handshake. Classification priority and record format match the unittest `.ans` trace: `N:$r=0x..`, `N:hi=..,lo=..`, `N:cp0.$r=..`, `N:skip`.

---
 rtl/commit_trace_buffer_if.sv | 37 +++
 rtl/commit_trace_buffer.sv | 115 +++++++++++
 tb/tb_commit_trace_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Commit-event inputs and trace-drain outputs of the commit trace buffer.
// The slave side is the buffer; the master side is the CPU/consumer environment.
interface commit_trace_buffer_if;
    logic        capture_en;
    logic        reg_write_enable;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        hilo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [1:0]  trace_kind;
    logic [15:0] trace_index;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data0;
    logic [31:0] trace_data1;
    logic        overflow;
    logic [15:0] drop_count;

    modport master (
        output capture_en, reg_write_enable, reg_write_addr, reg_write_data,
               hilo_we, hi_data, lo_data, cp0_we, cp0_waddr, cp0_wdata, trace_ready,
        input  trace_valid, trace_kind, trace_index, trace_addr, trace_data0,
               trace_data1, overflow, drop_count
    );

    modport slave (
        input  capture_en, reg_write_enable, reg_write_addr, reg_write_data,
               hilo_we, hi_data, lo_data, cp0_we, cp0_waddr, cp0_wdata, trace_ready,
        output trace_valid, trace_kind, trace_index, trace_addr, trace_data0,
               trace_data1, overflow, drop_count
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Classifies each captured commit cycle, tags it with a running cycle index and
// queues it in a FIFO drained through a valid/ready handshake.
module commit_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int CAPTURE_SKIP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_trace_buffer_if.slave  bus
);
    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        KIND_SKIP = 2'd0,
        KIND_GPR  = 2'd1,
        KIND_HILO = 2'd2,
        KIND_CP0  = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [15:0] index;
        logic [4:0]  addr;
        logic [31:0] data0;
        logic [31:0] data1;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_index;
    logic            r_overflow;
    logic [15:0]     r_drop_count;

    entry_t          w_entry;
    entry_t          w_head;
    logic [15:0]     w_next_index;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_write;
    logic            w_drop;
    logic            w_valid;

    assign w_next_index = r_index + 16'd1;

    // Fixed priority: GPR over HI/LO over CP0; lower-priority writes are lost.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        w_entry       = '0;
        w_entry.index = w_next_index;
        if (bus.reg_write_enable) begin
            w_entry.kind  = KIND_GPR;
            w_entry.addr  = bus.reg_write_addr;
            w_entry.data0 = bus.reg_write_data;
        end else if (bus.hilo_we) begin
            w_entry.kind  = KIND_HILO;
            w_entry.data0 = bus.hi_data;
            w_entry.data1 = bus.lo_data;
        end else if (bus.cp0_we) begin
            w_entry.kind  = KIND_CP0;
            w_entry.addr  = bus.cp0_waddr;
            w_entry.data0 = bus.cp0_wdata;
        end
    end

    assign w_push  = bus.capture_en && ((w_entry.kind != KIND_SKIP) || (CAPTURE_SKIP != 0));
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = w_valid && bus.trace_ready;
    assign w_write = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // NOTE: storage is not reset; r_count alone decides which slots hold data.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (bus.capture_en) r_index <= w_next_index;
            if (w_write)        r_wptr  <= r_wptr + AW'(1);
            if (w_pop)          r_rptr  <= r_rptr + AW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Head is shown straight from storage and forced to zero when empty.
    assign w_head          = w_valid ? r_mem[r_rptr] : '0;
    assign bus.trace_valid = w_valid;
    assign bus.trace_kind  = w_head.kind;
    assign bus.trace_index = w_head.index;
    assign bus.trace_addr  = w_head.addr;
    assign bus.trace_data0 = w_head.data0;
    assign bus.trace_data1 = w_head.data1;
    assign bus.overflow    = r_overflow;
    assign bus.drop_count  = r_drop_count;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a per-cycle vector table plus
// hand-written sequences for overflow, full throughput, skip filtering, wrap and reset.
module tb_commit_trace_buffer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    commit_trace_buffer_if bus_a ();
    commit_trace_buffer_if bus_b ();

    commit_trace_buffer #(.DEPTH(16), .CAPTURE_SKIP(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    commit_trace_buffer #(.DEPTH(16), .CAPTURE_SKIP(0)) u_dut_noskip (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic        cap;
        logic        rwe;
        logic [4:0]  raddr;
        logic [31:0] rdata;
        logic        hwe;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        cwe;
        logic [4:0]  caddr;
        logic [31:0] cdata;
        logic        ready;
        logic        e_valid;
        logic [1:0]  e_kind;
        logic [15:0] e_index;
        logic [4:0]  e_addr;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit inputs go to both instances; trace_ready is driven per instance.
    task automatic set_commit(input logic cap, input logic rwe, input logic [4:0] raddr,
                              input logic [31:0] rdata, input logic hwe, input logic [31:0] hi,
                              input logic [31:0] lo, input logic cwe, input logic [4:0] caddr,
                              input logic [31:0] cdata);
        bus_a.capture_en = cap;  bus_b.capture_en = cap;
        bus_a.reg_write_enable = rwe; bus_b.reg_write_enable = rwe;
        bus_a.reg_write_addr = raddr; bus_b.reg_write_addr = raddr;
        bus_a.reg_write_data = rdata; bus_b.reg_write_data = rdata;
        bus_a.hilo_we = hwe; bus_b.hilo_we = hwe;
        bus_a.hi_data = hi;  bus_b.hi_data = hi;
        bus_a.lo_data = lo;  bus_b.lo_data = lo;
        bus_a.cp0_we = cwe;  bus_b.cp0_we = cwe;
        bus_a.cp0_waddr = caddr; bus_b.cp0_waddr = caddr;
        bus_a.cp0_wdata = cdata; bus_b.cp0_wdata = cdata;
    endtask

    task automatic idle(input logic cap);
        set_commit(cap, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        idle(1'b0);
        bus_a.trace_ready = 1'b0;
        bus_b.trace_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 5'd1,  32'h101,      1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b1, 2'd1, 16'd1, 5'd1,  32'h101, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b1, 2'd0, 16'd2, 5'd0,  32'h0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 5'd3,  32'h5,        1'b1, 32'hAA, 32'hBB, 1'b1, 5'd7, 32'h77, 1'b1,
                     1'b1, 2'd1, 16'd3, 5'd3,  32'h5, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 5'd5,  32'hDEAD,     1'b1, 32'h1, 32'h2, 1'b0, 5'd9, 32'h99, 1'b1,
                     1'b1, 2'd2, 16'd4, 5'd0,  32'h1, 32'h2};
        vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 1'b1, 5'd11, 32'h100, 1'b1,
                     1'b1, 2'd3, 16'd5, 5'd11, 32'h100, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5'd4, 32'h44, 1'b1,
                     1'b1, 2'd2, 16'd6, 5'd0,  32'h12345678, 32'h9ABCDEF0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b0, 2'd0, 16'd0, 5'd0,  32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 5'd2,  32'h22,       1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b0, 2'd0, 16'd0, 5'd0,  32'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b1, 2'd1, 16'd7, 5'd31, 32'hFFFFFFFF, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b1, 2'd1, 16'd7, 5'd31, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b1, 2'd0, 16'd8, 5'd0,  32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b0, 2'd0, 16'd0, 5'd0,  32'h0, 32'h0};

        // Reset state
        rst = 1'b1;
        idle(1'b0);
        bus_a.trace_ready = 1'b0;
        bus_b.trace_ready = 1'b0;
        tick();
        check("reset.valid", 32'(bus_a.trace_valid), 32'd0);
        check("reset.index", 32'(bus_a.trace_index), 32'd0);
        check("reset.overflow", 32'(bus_a.overflow), 32'd0);
        check("reset.drop_count", 32'(bus_a.drop_count), 32'd0);
        rst = 1'b0;

        // Vector table: one capture edge per row, head checked just after the edge
        bus_b.trace_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_commit(vecs[i].cap, vecs[i].rwe, vecs[i].raddr, vecs[i].rdata, vecs[i].hwe,
                       vecs[i].hi, vecs[i].lo, vecs[i].cwe, vecs[i].caddr, vecs[i].cdata);
            bus_a.trace_ready = vecs[i].ready;
            tick();
            check($sformatf("v%0d.valid", i), 32'(bus_a.trace_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d.kind", i),  32'(bus_a.trace_kind),  32'(vecs[i].e_kind));
            check($sformatf("v%0d.index", i), 32'(bus_a.trace_index), 32'(vecs[i].e_index));
            check($sformatf("v%0d.addr", i),  32'(bus_a.trace_addr),  32'(vecs[i].e_addr));
            check($sformatf("v%0d.data0", i), bus_a.trace_data0, vecs[i].e_d0);
            check($sformatf("v%0d.data1", i), bus_a.trace_data1, vecs[i].e_d1);
        end
        check("table.overflow", 32'(bus_a.overflow), 32'd0);

        // Overflow: 20 captures into a 16-deep FIFO with the consumer stalled
        do_reset();
        idle(1'b1);
        for (int c = 1; c <= 20; c++) begin
            tick();
            check($sformatf("ovf.c%0d.valid", c), 32'(bus_a.trace_valid), 32'd1);
            check($sformatf("ovf.c%0d.head_index", c), 32'(bus_a.trace_index), 32'd1);
        end
        check("ovf.overflow", 32'(bus_a.overflow), 32'd1);
        check("ovf.drop_count", 32'(bus_a.drop_count), 32'd4);
        idle(1'b0);
        bus_a.trace_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("ovf.drain%0d.index", k), 32'(bus_a.trace_index), 32'(k));
            tick();
        end
        check("ovf.drained.valid", 32'(bus_a.trace_valid), 32'd0);
        check("ovf.sticky.overflow", 32'(bus_a.overflow), 32'd1);
        check("ovf.sticky.drop_count", 32'(bus_a.drop_count), 32'd4);

        // Asynchronous reset with entries queued, observed before the next edge
        bus_a.trace_ready = 1'b0;
        idle(1'b1);
        repeat (3) tick();
        check("midrst.pre.valid", 32'(bus_a.trace_valid), 32'd1);
        idle(1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst.valid", 32'(bus_a.trace_valid), 32'd0);
        check("midrst.index", 32'(bus_a.trace_index), 32'd0);
        check("midrst.overflow", 32'(bus_a.overflow), 32'd0);
        check("midrst.drop_count", 32'(bus_a.drop_count), 32'd0);
        tick();
        rst = 1'b0;

        // Full FIFO with simultaneous push and pop: no drops, occupancy stays 16
        do_reset();
        idle(1'b1);
        repeat (16) tick();
        check("full.head_index", 32'(bus_a.trace_index), 32'd1);
        bus_a.trace_ready = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check($sformatf("full.pp%0d.index", j), 32'(bus_a.trace_index), 32'(1 + j));
            check($sformatf("full.pp%0d.drop_count", j), 32'(bus_a.drop_count), 32'd0);
        end
        idle(1'b0);
        for (int k = 11; k <= 26; k++) begin
            check($sformatf("full.drain%0d.index", k), 32'(bus_a.trace_index), 32'(k));
            tick();
        end
        check("full.drained.valid", 32'(bus_a.trace_valid), 32'd0);
        check("full.overflow", 32'(bus_a.overflow), 32'd0);

        // Skip cycles not stored: writes only on capture cycles 2 and 5
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            if (c == 2)      set_commit(1'b1, 1'b1, 5'd2, 32'h22, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
            else if (c == 5) set_commit(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0);
            else             idle(1'b1);
            tick();
        end
        idle(1'b0);
        check("noskip.e0.valid", 32'(bus_b.trace_valid), 32'd1);
        check("noskip.e0.kind", 32'(bus_b.trace_kind), 32'd1);
        check("noskip.e0.index", 32'(bus_b.trace_index), 32'd2);
        check("noskip.e0.data0", bus_b.trace_data0, 32'h22);
        bus_b.trace_ready = 1'b1;
        tick();
        check("noskip.e1.kind", 32'(bus_b.trace_kind), 32'd2);
        check("noskip.e1.index", 32'(bus_b.trace_index), 32'd5);
        check("noskip.e1.data1", bus_b.trace_data1, 32'h66);
        tick();
        check("noskip.empty.valid", 32'(bus_b.trace_valid), 32'd0);

        // Index wrap 0xFFFF -> 0x0000, then reset with five entries queued
        do_reset();
        bus_a.trace_ready = 1'b1;
        idle(1'b1);
        repeat (65535) tick();
        check("wrap.ffff.valid", 32'(bus_a.trace_valid), 32'd1);
        check("wrap.ffff.index", 32'(bus_a.trace_index), 32'h0000FFFF);
        tick();
        check("wrap.zero.index", 32'(bus_a.trace_index), 32'd0);
        bus_a.trace_ready = 1'b0;
        repeat (4) tick();
        check("wrap.queued.head", 32'(bus_a.trace_index), 32'd0);
        idle(1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("wrap.rst.valid", 32'(bus_a.trace_valid), 32'd0);
        check("wrap.rst.overflow", 32'(bus_a.overflow), 32'd0);
        check("wrap.rst.index", 32'(bus_a.trace_index), 32'd0);
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
